kf8255_bus_control: RTL and testbench

Bus-side front end of the KF8255 PPI. It samples the CPU bus, decodes the 2-bit port address, and turns each completed write into a one-clock strobe: write_port_a, write_port_b, write_port_c, write_port_c_bit_set or the mode-update pair. It also holds the mode/direction registers and drives level read-select signals. All outputs feed the Port A/B/C stages directly downstream.

---
 rtl/kf8255_bus_control.sv | 121 ++++++++++++
 tb/tb_kf8255_bus_control.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/kf8255_bus_control.sv
// kf8255_bus_control: CPU bus front end of the KF8255 PPI (write strobes, read selects, mode registers).
// Optional 2-flop bus synchronizer enabled by defining KF8255_BUS_SYNC_EN.
module kf8255_bus_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       chip_select_n,
    input  logic       read_enable_n,
    input  logic       write_enable_n,
    input  logic [1:0] address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_data_bus,
    output logic       write_port_a,
    output logic       write_port_b,
    output logic       write_port_c,
    output logic       write_port_c_bit_set,
    output logic       update_group_a_mode,
    output logic       update_group_b_mode,
    output logic       read_port_a,
    output logic       read_port_b,
    output logic       read_port_c,
    output logic [1:0] group_a_mode_reg,
    output logic [1:0] group_b_mode_reg,
    output logic       group_a_port_a_io_reg,
    output logic       group_a_port_c_io_reg,
    output logic       group_b_port_b_io_reg,
    output logic       group_b_port_c_io_reg
);
    logic       s_cs_n, s_rd_n, s_we_n;
    logic [1:0] s_addr;
    logic [7:0] s_data;
    logic       prev_we_n, cs_seen, done;
    logic [1:0] addr_latch;
    logic [7:0] data_latch;

`ifdef KF8255_BUS_SYNC_EN
    // data is delayed alongside the controls so the capture sees an aligned sample
    logic [2:0] ctl_1, ctl_2;
    logic [1:0] addr_1, addr_2;
    logic [7:0] data_1, data_2;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctl_1  <= 3'b111;
            ctl_2  <= 3'b111;
            addr_1 <= 2'b00;
            addr_2 <= 2'b00;
            data_1 <= 8'h00;
            data_2 <= 8'h00;
        end else begin
            ctl_1  <= {chip_select_n, read_enable_n, write_enable_n};
            ctl_2  <= ctl_1;
            addr_1 <= address;
            addr_2 <= addr_1;
            data_1 <= data_bus_in;
            data_2 <= data_1;
        end
    end
    assign {s_cs_n, s_rd_n, s_we_n} = ctl_2;
    assign s_addr = addr_2;
    assign s_data = data_2;
`else
    assign {s_cs_n, s_rd_n, s_we_n} = {chip_select_n, read_enable_n, write_enable_n};
    assign s_addr = address;
    assign s_data = data_bus_in;
`endif

    assign done = ~prev_we_n & s_we_n & cs_seen;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_we_n             <= 1'b1;
            cs_seen               <= 1'b0;
            addr_latch            <= 2'b00;
            data_latch            <= 8'h00;
            internal_data_bus     <= 8'h00;
            write_port_a          <= 1'b0;
            write_port_b          <= 1'b0;
            write_port_c          <= 1'b0;
            write_port_c_bit_set  <= 1'b0;
            update_group_a_mode   <= 1'b0;
            update_group_b_mode   <= 1'b0;
            read_port_a           <= 1'b0;
            read_port_b           <= 1'b0;
            read_port_c           <= 1'b0;
            group_a_mode_reg      <= 2'b00;
            group_b_mode_reg      <= 2'b00;
            group_a_port_a_io_reg <= 1'b1;
            group_a_port_c_io_reg <= 1'b1;
            group_b_port_b_io_reg <= 1'b1;
            group_b_port_c_io_reg <= 1'b1;
        end else begin
            prev_we_n <= s_we_n;
            if (!s_we_n && !s_cs_n) begin
                data_latch <= s_data;
                addr_latch <= s_addr;
            end
            cs_seen <= done ? 1'b0 : (!s_we_n && !s_cs_n) ? 1'b1 : cs_seen;
            if (done)
                internal_data_bus <= data_latch;
            write_port_a         <= done & (addr_latch == 2'd0);
            write_port_b         <= done & (addr_latch == 2'd1);
            write_port_c         <= done & (addr_latch == 2'd2);
            write_port_c_bit_set <= done & (addr_latch == 2'd3) & ~data_latch[7];
            update_group_a_mode  <= done & (addr_latch == 2'd3) & data_latch[7];
            update_group_b_mode  <= done & (addr_latch == 2'd3) & data_latch[7];
            read_port_a <= ~s_cs_n & ~s_rd_n & s_we_n & (s_addr == 2'd0);
            read_port_b <= ~s_cs_n & ~s_rd_n & s_we_n & (s_addr == 2'd1);
            read_port_c <= ~s_cs_n & ~s_rd_n & s_we_n & (s_addr == 2'd2);
            // mode takes effect on the edge that ends the update strobe
            if (update_group_a_mode) begin
                group_a_mode_reg      <= data_latch[6:5];
                group_a_port_a_io_reg <= data_latch[4];
                group_a_port_c_io_reg <= data_latch[3];
            end
            if (update_group_b_mode) begin
                group_b_mode_reg      <= {1'b0, data_latch[2]};
                group_b_port_b_io_reg <= data_latch[1];
                group_b_port_c_io_reg <= data_latch[0];
            end
        end
    end
endmodule

// File: tb/tb_kf8255_bus_control.sv
// tb_kf8255_bus_control: scoreboard bench for the KF8255 bus front end.
module tb_kf8255_bus_control;
`ifdef KF8255_BUS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    logic       clock = 0, reset_n = 0;
    logic       chip_select_n = 1, read_enable_n = 1, write_enable_n = 1;
    logic [1:0] address = 0;
    logic [7:0] data_bus_in = 0, internal_data_bus;
    logic       write_port_a, write_port_b, write_port_c, write_port_c_bit_set;
    logic       update_group_a_mode, update_group_b_mode;
    logic       read_port_a, read_port_b, read_port_c;
    logic [1:0] group_a_mode_reg, group_b_mode_reg;
    logic       group_a_port_a_io_reg, group_a_port_c_io_reg;
    logic       group_b_port_b_io_reg, group_b_port_c_io_reg;

    typedef struct {logic [5:0] vec; logic [7:0] data;} exp_t;
    exp_t q[$];
    exp_t mon_e;
    int tests = 0, failed = 0;
    logic [1:0] strobe_mode;
    logic [5:0] strobes;
    logic [2:0] reads;
    logic [3:0] ios;

    assign strobes = {write_port_a, write_port_b, write_port_c, write_port_c_bit_set,
                      update_group_a_mode, update_group_b_mode};
    assign reads = {read_port_a, read_port_b, read_port_c};
    assign ios = {group_a_port_a_io_reg, group_a_port_c_io_reg,
                  group_b_port_b_io_reg, group_b_port_c_io_reg};

    kf8255_bus_control dut (
        .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n),
        .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
        .address(address), .data_bus_in(data_bus_in), .internal_data_bus(internal_data_bus),
        .write_port_a(write_port_a), .write_port_b(write_port_b), .write_port_c(write_port_c),
        .write_port_c_bit_set(write_port_c_bit_set), .update_group_a_mode(update_group_a_mode),
        .update_group_b_mode(update_group_b_mode), .read_port_a(read_port_a),
        .read_port_b(read_port_b), .read_port_c(read_port_c),
        .group_a_mode_reg(group_a_mode_reg), .group_b_mode_reg(group_b_mode_reg),
        .group_a_port_a_io_reg(group_a_port_a_io_reg), .group_a_port_c_io_reg(group_a_port_c_io_reg),
        .group_b_port_b_io_reg(group_b_port_b_io_reg), .group_b_port_c_io_reg(group_b_port_c_io_reg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // every strobe seen must match the oldest pending write
    always @(negedge clock) begin
        if (reset_n && strobes != 6'd0) begin
            if (q.size() == 0)
                check("spurious_strobe", {10'd0, strobes}, 16'd0);
            else begin
                mon_e = q.pop_front();
                check("strobe_vec", {10'd0, strobes}, {10'd0, mon_e.vec});
                check("strobe_data", {8'd0, internal_data_bus}, {8'd0, mon_e.data});
                strobe_mode = group_a_mode_reg;
            end
        end
    end

    task automatic start_wr(input logic [1:0] a, input logic [7:0] d, input logic cs, input logic [5:0] vec);
        if (vec != 6'd0)
            q.push_back('{vec, d});
        chip_select_n = cs;
        address = a;
        data_bus_in = d;
        write_enable_n = 0;
    endtask

    task automatic end_wr(input string tag, input logic [5:0] vec);
        repeat (LAT + 1) @(negedge clock);
        write_enable_n = 1;
        chip_select_n = 1;
        data_bus_in = 8'hEE;
        repeat (LAT) @(negedge clock);
        #1;
        check({tag, "_timing"}, {10'd0, strobes}, {10'd0, vec});
        check({tag, "_drained"}, q.size(), 16'd0);
        @(negedge clock);
        #1;
        check({tag, "_one_clock"}, {10'd0, strobes}, 16'd0);
    endtask

    task automatic wr(input string tag, input logic [1:0] a, input logic [7:0] d, input logic cs, input logic [5:0] vec);
        start_wr(a, d, cs, vec);
        end_wr(tag, vec);
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [2:0] exp);
        chip_select_n = 0;
        read_enable_n = 0;
        address = a;
        repeat (LAT) @(negedge clock);
        #1;
        check({tag, "_on"}, {13'd0, reads}, {13'd0, exp});
        read_enable_n = 1;
        chip_select_n = 1;
        repeat (LAT) @(negedge clock);
        #1;
        check({tag, "_off"}, {13'd0, reads}, 16'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        #1;
        check("rst_modes", {12'd0, group_a_mode_reg, group_b_mode_reg}, 16'd0);
        check("rst_io", {12'd0, ios}, 16'h000F);
        check("rst_strobes", {10'd0, strobes}, 16'd0);
        check("rst_reads", {13'd0, reads}, 16'd0);
        check("rst_idb", {8'd0, internal_data_bus}, 16'd0);

        wr("wr_a", 2'd0, 8'h55, 0, 6'b100000);
        check("idb_hold", {8'd0, internal_data_bus}, 16'h0055);
        wr("wr_b", 2'd1, 8'hA3, 0, 6'b010000);
        wr("wr_c", 2'd2, 8'h0C, 0, 6'b001000);

        strobe_mode = 2'b11;
        wr("mode", 2'd3, 8'hB6, 0, 6'b000011);
        check("mode_old_in_strobe", {14'd0, strobe_mode}, 16'd0);
        check("mode_a", {14'd0, group_a_mode_reg}, 16'd1);
        check("mode_b", {14'd0, group_b_mode_reg}, 16'd1);
        check("mode_io", {12'd0, ios}, 16'b1010);

        wr("bitset", 2'd3, 8'h0F, 0, 6'b000100);
        check("bitset_modes", {12'd0, group_a_mode_reg, group_b_mode_reg}, 16'b0101);
        check("bitset_io", {12'd0, ios}, 16'b1010);

        wr("no_cs", 2'd0, 8'h77, 1, 6'd0);
        check("no_cs_idb", {8'd0, internal_data_bus}, 16'h000F);

        rd("rd_a", 2'd0, 3'b100);
        rd("rd_b", 2'd1, 3'b010);
        rd("rd_c", 2'd2, 3'b001);
        rd("rd_ctl", 2'd3, 3'b000);

        // read and write together: write strobes, reads stay low
        start_wr(2'd2, 8'h99, 0, 6'b001000);
        read_enable_n = 0;
        repeat (LAT) @(negedge clock);
        #1;
        check("rw_no_read", {13'd0, reads}, 16'd0);
        read_enable_n = 1;
        end_wr("rw", 6'b001000);

        // reset while write is low; rising edge lands inside reset
        start_wr(2'd0, 8'hAA, 0, 6'd0);
        repeat (LAT + 1) @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        write_enable_n = 1;
        chip_select_n = 1;
        @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clock);
            #1;
            check("rst_mid_strobe", {10'd0, strobes}, 16'd0);
        end
        check("rst_mid_idb", {8'd0, internal_data_bus}, 16'd0);
        check("rst_mid_mode", {12'd0, group_a_mode_reg, group_b_mode_reg}, 16'd0);

        // reset pulse while write is still low afterwards: captured afresh
        start_wr(2'd1, 8'h3C, 0, 6'b010000);
        repeat (2) @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        repeat (LAT) @(negedge clock);
        end_wr("fresh", 6'b010000);

        check("queue_empty", q.size(), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
